psg_accum_scheduler: RTL and testbench

Time-multiplexed phase-accumulator engine for the PSG. A single shared WID-bit adder serves NVOICE voices; each voice has its own frequency register, test bit and one-shot sync request. A sample `tick` starts one sweep that updates every voice's phase once, in voice order. Phases stream out to the downstream waveform generators with a voice tag.

---
 rtl/psg_pkg.sv | 12 +
 rtl/psg_voice_regfile.sv | 72 +++++++
 rtl/psg_accum_scheduler.sv | 134 +++++++++++++
 tb/tb_psg_accum_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared types and control-word bit positions for the PSG phase-accumulator scheduler.
package psg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } psg_sched_state_t;

  localparam int PSG_CTRL_TEST = 0;
  localparam int PSG_CTRL_SYNC = 1;

endpackage

// File: rtl/psg_voice_regfile.sv
// Per-voice frequency, test, sync-request and accumulator storage with a bus write port
// and a slot-indexed read/writeback port for the shared adder.
module psg_voice_regfile
  import psg_pkg::*;
#(
  parameter int WID    = 32,
  parameter int NVOICE = 8,
  parameter int VW     = $clog2(NVOICE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_freq,
  input  logic           wr_ctrl,
  input  logic [VW-1:0]  wadr,
  input  logic [WID-1:0] wdat,
  input  logic [VW-1:0]  rslot,
  output logic [WID-1:0] rd_freq,
  output logic [WID-1:0] rd_acc,
  output logic           rd_test,
  output logic           rd_sync,
  input  logic           acc_we,
  input  logic [WID-1:0] acc_wdat,
  input  logic           sync_clr
);

  logic [WID-1:0]    freq_reg [NVOICE];
  logic [WID-1:0]    acc_reg  [NVOICE];
  logic [NVOICE-1:0] test_reg;
  logic [NVOICE-1:0] sync_reg;
  logic [NVOICE-1:0] whit;
  logic [NVOICE-1:0] shit;

  // Address decode only matches real voices, so out-of-range addresses fall through silently.
  genvar gi;
  generate
    for (gi = 0; gi < NVOICE; gi++) begin : g_dec
      assign whit[gi] = (wadr == VW'(gi));
      assign shit[gi] = (rslot == VW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NVOICE; i++) begin
        freq_reg[i] <= '0;
        acc_reg[i]  <= '0;
      end
      test_reg <= '0;
      sync_reg <= '0;
    end else begin
      for (int i = 0; i < NVOICE; i++) begin
        if (wr_freq && whit[i])
          freq_reg[i] <= wdat;
        if (wr_ctrl && whit[i])
          test_reg[i] <= wdat[PSG_CTRL_TEST];
        // A fresh request beats the service-side clear landing on the same edge.
        if (wr_ctrl && whit[i] && wdat[PSG_CTRL_SYNC])
          sync_reg[i] <= 1'b1;
        else if (sync_clr && shit[i])
          sync_reg[i] <= 1'b0;
        if (acc_we && shit[i])
          acc_reg[i] <= acc_wdat;
      end
    end
  end

  assign rd_freq = freq_reg[rslot];
  assign rd_acc  = acc_reg[rslot];
  assign rd_test = test_reg[rslot];
  assign rd_sync = sync_reg[rslot];

endmodule

// File: rtl/psg_accum_scheduler.sv
// Sweep scheduler: one shared adder steps every voice's phase once per tick, in voice order,
// and streams the updated phases out with a voice tag.
module psg_accum_scheduler
  import psg_pkg::*;
#(
  parameter int WID    = 32,
  parameter int NVOICE = 8,
  parameter int VW     = $clog2(NVOICE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           wr_freq,
  input  logic           wr_ctrl,
  input  logic [VW-1:0]  wadr,
  input  logic [WID-1:0] wdat,
  input  logic           ovr_clr,
  output logic [WID-1:0] o,
  output logic           ov,
  output logic [VW-1:0]  ovoice,
  output logic           busy,
  output logic           done,
  output logic           overrun
);

  psg_sched_state_t state_reg, state_next;
  logic [VW-1:0]  slot_reg, slot_next;
  logic [WID-1:0] o_reg, o_next;
  logic [VW-1:0]  ovoice_reg, ovoice_next;
  logic           ov_reg, ov_next;
  logic           done_reg, done_next;
  logic           overrun_reg, overrun_next;

  logic [WID-1:0] rd_freq, rd_acc, acc_new;
  logic           rd_test, rd_sync, acc_we, sync_clr;

  psg_voice_regfile #(
    .WID    (WID),
    .NVOICE (NVOICE),
    .VW     (VW)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .wr_freq  (wr_freq),
    .wr_ctrl  (wr_ctrl),
    .wadr     (wadr),
    .wdat     (wdat),
    .rslot    (slot_reg),
    .rd_freq  (rd_freq),
    .rd_acc   (rd_acc),
    .rd_test  (rd_test),
    .rd_sync  (rd_sync),
    .acc_we   (acc_we),
    .acc_wdat (acc_new),
    .sync_clr (sync_clr)
  );

  always_comb begin
    state_next  = state_reg;
    slot_next   = slot_reg;
    o_next      = o_reg;
    ovoice_next = ovoice_reg;
    ov_next     = 1'b0;
    done_next   = 1'b0;
    acc_we      = 1'b0;
    sync_clr    = 1'b0;
    acc_new     = rd_acc + rd_freq;
    case (state_reg)
      IDLE: begin
        if (tick) begin
          state_next = RUN;
          slot_next  = '0;
        end
      end
      RUN: begin
        acc_we = 1'b1;
        // Test hold outranks a pending sync, which then stays pending.
        if (rd_test) begin
          acc_new = '0;
        end else if (rd_sync) begin
          acc_new  = '0;
          sync_clr = 1'b1;
        end
        o_next      = acc_new;
        ovoice_next = slot_reg;
        ov_next     = 1'b1;
        if (slot_reg == VW'(NVOICE - 1)) begin
          done_next  = 1'b1;
          state_next = IDLE;
          slot_next  = '0;
        end else begin
          slot_next = slot_reg + VW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    overrun_next = overrun_reg;
    if (ovr_clr)
      overrun_next = 1'b0;
    if (tick && state_reg == RUN)
      overrun_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      slot_reg    <= '0;
      o_reg       <= '0;
      ovoice_reg  <= '0;
      ov_reg      <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      slot_reg    <= slot_next;
      o_reg       <= o_next;
      ovoice_reg  <= ovoice_next;
      ov_reg      <= ov_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  assign o       = o_reg;
  assign ov      = ov_reg;
  assign ovoice  = ovoice_reg;
  assign done    = done_reg;
  assign overrun = overrun_reg;
  assign busy    = (state_reg == RUN);

endmodule

// File: tb/tb_psg_accum_scheduler.sv
// Scoreboard bench: a sweep-level reference model predicts every phase output, a monitor
// checks the DUT stream plus busy/overrun/held outputs each cycle.
module tb_psg_accum_scheduler;

  localparam int WID    = 32;
  localparam int NVOICE = 8;
  localparam int VW     = $clog2(NVOICE);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tick = 1'b0;
  logic           wr_freq = 1'b0;
  logic           wr_ctrl = 1'b0;
  logic [VW-1:0]  wadr = '0;
  logic [WID-1:0] wdat = '0;
  logic           ovr_clr = 1'b0;
  logic [WID-1:0] o;
  logic           ov;
  logic [VW-1:0]  ovoice;
  logic           busy;
  logic           done;
  logic           overrun;

  psg_accum_scheduler #(
    .WID    (WID),
    .NVOICE (NVOICE),
    .VW     (VW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .wr_freq (wr_freq),
    .wr_ctrl (wr_ctrl),
    .wadr    (wadr),
    .wdat    (wdat),
    .ovr_clr (ovr_clr),
    .o       (o),
    .ov      (ov),
    .ovoice  (ovoice),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WID-1:0] o;
    int             v;
    bit             done;
  } exp_t;

  exp_t sb[$];

  // Reference model: voice behaviour described directly; a sweep is just "voices left to serve".
  logic [WID-1:0] m_freq [NVOICE];
  logic [WID-1:0] m_acc  [NVOICE];
  bit             m_test [NVOICE];
  bit             m_sync [NVOICE];
  int             pend;
  bit             m_ovr;
  logic [WID-1:0] hold_o;
  int             hold_v;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NVOICE; i++) begin
          m_freq[i] = '0; m_acc[i] = '0; m_test[i] = 0; m_sync[i] = 0;
        end
        pend = 0; m_ovr = 0; hold_o = '0; hold_v = 0;
        sb.delete();
      end else begin
        bit was_idle;
        was_idle = (pend == 0);
        if (!was_idle) begin
          int v;
          logic [WID-1:0] nv;
          exp_t e;
          v = NVOICE - pend;
          if (m_test[v]) nv = '0;
          else if (m_sync[v]) begin nv = '0; m_sync[v] = 0; end
          else nv = m_acc[v] + m_freq[v];
          m_acc[v] = nv;
          e.o = nv; e.v = v; e.done = (v == NVOICE - 1);
          sb.push_back(e);
          hold_o = nv; hold_v = v;
          pend--;
        end
        if (wr_freq && int'(wadr) < NVOICE) m_freq[wadr] = wdat;
        if (wr_ctrl && int'(wadr) < NVOICE) begin
          m_test[wadr] = wdat[0];
          if (wdat[1]) m_sync[wadr] = 1;
        end
        if (ovr_clr) m_ovr = 0;
        if (tick) begin
          if (was_idle) pend = NVOICE;
          else m_ovr = 1;
        end
      end
    end
  end

  // Monitor
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (ov) begin
        if (sb.size() == 0) begin
          check("unexpected_ov", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn voice=%0d o=%08h done=%0b (exp voice=%0d o=%08h done=%0b)",
                   ovoice, o, done, e.v, e.o, e.done);
          check("phase", o, e.o);
          check("ovoice", ovoice, e.v);
          check("done", done, e.done);
        end
      end else begin
        check("done_idle", done, 0);
        check("o_hold", o, hold_o);
        check("ovoice_hold", ovoice, hold_v);
      end
      check("busy", busy, pend != 0);
      check("overrun", overrun, m_ovr);
    end
  end

  // One bus cycle, launched on a falling edge.
  task automatic cyc(input bit t, input bit wf, input bit wc, input int adr,
                     input logic [WID-1:0] dat, input bit clr);
    tick = t; wr_freq = wf; wr_ctrl = wc; wadr = VW'(adr); wdat = dat; ovr_clr = clr;
    @(negedge clk);
    tick = 0; wr_freq = 0; wr_ctrl = 0; ovr_clr = 0;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, 0);
  endtask

  task automatic sweep();
    cyc(1, 0, 0, 0, '0, 0);
    nop(NVOICE + 1);
  endtask

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    nop(2);

    for (int v = 0; v < NVOICE; v++) cyc(0, 1, 0, v, WID'(v + 1), 0);
    sweep();
    sweep();

    cyc(0, 1, 0, 3, 32'hFFFF_FFF0, 0);
    sweep(); sweep(); sweep();

    cyc(0, 0, 1, 2, 32'd1, 0);
    sweep(); sweep();
    cyc(0, 0, 1, 2, 32'd0, 0);
    sweep();

    cyc(0, 0, 1, 5, 32'd2, 0);
    sweep(); sweep();
    // Sync write landing on voice 5's own service edge.
    cyc(1, 0, 0, 0, '0, 0);
    nop(5);
    cyc(0, 0, 1, 5, 32'd2, 0);
    nop(3);
    sweep();

    // Overrun: tick mid-sweep, then clear, then clear+tick together.
    cyc(1, 0, 0, 0, '0, 0);
    nop(2);
    cyc(1, 0, 0, 0, '0, 0);
    nop(NVOICE + 2);
    cyc(0, 0, 0, 0, '0, 1);
    cyc(1, 0, 0, 0, '0, 0);
    nop(2);
    cyc(1, 0, 0, 0, '0, 1);
    nop(NVOICE + 2);
    cyc(0, 0, 0, 0, '0, 1);

    // Tick on the done edge counts as overrun; next one starts immediately after.
    cyc(1, 0, 0, 0, '0, 0);
    nop(NVOICE - 1);
    cyc(1, 0, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, '0, 0);
    nop(NVOICE + 1);

    // Reset mid-sweep.
    cyc(1, 0, 0, 0, '0, 0);
    nop(3);
    rst = 1;
    @(negedge clk);
    rst = 0;
    nop(1);
    cyc(0, 1, 0, 0, 32'd7, 0);
    sweep();

    for (int i = 0; i < 600; i++) begin
      bit t, wf, wc, clr;
      logic [WID-1:0] d;
      t   = ($urandom_range(5) == 0);
      wf  = ($urandom_range(7) == 0);
      wc  = ($urandom_range(7) == 0);
      clr = ($urandom_range(9) == 0);
      d   = $urandom;
      if (wc && !wf) d = {30'($urandom_range(3)), ($urandom_range(3) == 0), ($urandom_range(2) == 0)};
      if ($urandom_range(4) == 0) d = 32'hFFFF_FFFF - 32'($urandom_range(15));
      cyc(t, wf, wc, int'($urandom_range(NVOICE - 1)), d, clr);
    end
    nop(NVOICE + 4);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
